ifid_fetch_buffer: RTL and testbench
====================================

// Module: ifid_fetch_buffer
// PURPOSE
//  Decoupling buffer and IF/ID pipeline register between instruction memory and the decoder.
//  Queues {pc, inst} responses from inst_mem and presents one instruction per cycle to decode.
//  Honours the hazard unit's IFID_write stall and the kill/redirect flush.
//  On a flush it injects NOPs and discards responses still in flight.
// PARAMETERS
//  DEPTH         4             queue entries; power of two, >= 2
//  XLEN          32            instruction / PC width
//  NOP_INST      32'h00000013  addi x0,x0,0; emitted on bubble, flush and reset
//  DRAIN_CYCLES  1             cycles of inst_mem responses discarded after kill (memory latency)
// PORTS
//  clk               in   1     clock, rising edge
//  rst               in   1     reset, asynchronous, active-low (0 = reset)
//  fetch_data_valid  in   1     inst_mem response valid this cycle
//  fetch_data        in   XLEN  inst_mem response instruction
//  fetch_pc          in   XLEN  PC of the response instruction
//  fetch_ready       out  1     fetch may issue a request this cycle (comb)
//  ifid_write        in   1     advance enable from hazard unit; 0 = hold ID outputs
//  kill              in   1     flush: branch/jump redirect
//  id_inst           out  XLEN  instruction presented to decoder (registered)
//  id_pc             out  XLEN  PC of id_inst (registered)
//  id_valid          out  1     id_inst is a real fetched instruction (registered)
//  overflow          out  1     sticky: a response arrived with the queue full
// BEHAVIOUR
//  Reset (rst=0, async):
//   - id_inst=NOP_INST, id_pc=0, id_valid=0, overflow=0; queue empty, pointers 0; state RUN.
//   - After reset fetch_ready=1.
//  Queue pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. count: 0..DEPTH.
//  fetch_ready = (state==RUN) && (count <= DEPTH-2); reserves one slot for the 1-cycle mem latency.
//  Priority per cycle: kill > ifid_write advance > push.
//  kill=1 (ignores ifid_write and fetch_data_valid):
//   - next cycle: queue empty, id_inst=NOP_INST, id_valid=0, id_pc unchanged.
//   - state<=DRAIN, drain_cnt<=DRAIN_CYCLES.
//  DRAIN: fetch_data_valid responses are dropped (no push, no bypass, no overflow).
//   - drain_cnt decrements each cycle; at 0 the next state is RUN.
//   - kill in DRAIN reloads drain_cnt.
//  RUN, ifid_write=1:
//   - count>0: pop head into id_* with id_valid=1.
//   - count==0 && fetch_data_valid: bypass fetch_data/fetch_pc directly into id_* with id_valid=1,
//     no push; zero-bubble latency is 1 cycle response->ID.
//   - count==0 && !fetch_data_valid: id_inst=NOP_INST, id_valid=0, id_pc held.
//  RUN, ifid_write=0: id_* hold; no pop.
//  Push: RUN && fetch_data_valid && not bypassed.
//   - count<DEPTH: write at tail. Push+pop in one cycle: count unchanged, FIFO order preserved.
//   - count==DEPTH: response dropped, overflow<=1 (sticky until reset); a protocol-violation
//     indicator, not a recovery path.
//  Order: id_* sequence equals fetch response order, excluding flushed responses.
//  No combinational path from fetch_data_valid to fetch_ready.
// STRUCTURE
//  chronos_pkg:
//   - NOP_INST constant, XLEN.
//   - fetch state enum {RUN, DRAIN}.
//   - fetch entry struct {pc, inst}; shared with the decoder and the hazard unit.
//  Sub-module fetch_fifo:
//   - DEPTH x (2*XLEN) storage, push/pop/clear, count, full/empty.
//   - Asynchronous active-low reset plus synchronous clear (driven by kill).
//  Top level holds the state FSM, drain counter, bypass mux, ID output register and overflow flag.
// TESTING
//  1. Reset:
//     - rst=0 mid-stream with count=3 -> immediately id_inst=0x00000013, id_valid=0, overflow=0.
//     - After rst=1: fetch_ready=1.
//  2. Streaming:
//     - Responses 0x00500093@0x0, 0x00A00113@0x4 on consecutive cycles, ifid_write=1.
//     - -> id_* show each one cycle after arrival; count stays 0.
//  3. Stall:
//     - ifid_write=0 for 3 cycles while 3 responses arrive -> id_* frozen, count=3, fetch_ready=0.
//     - Release -> 3 pops in order, one per cycle.
//  4. Flush:
//     - kill with count=2 and a response in the same and next cycle.
//     - -> both responses dropped; id_inst=NOP, id_valid=0; RUN after 1 cycle; next response reaches ID.
//  5. Wrap:
//     - Push/pop 10 entries through DEPTH=4 with random stalls -> output order matches input, pointers wrap.
//  6. Overflow:
//     - Force 5 responses with ifid_write=0, ignoring fetch_ready -> 5th dropped, overflow=1 until reset.

Source files
------------

// File: rtl/chronos_pkg.sv
// Shared fetch-path definitions for the IF/ID buffer, decoder and hazard unit.
//   XLEN          instruction / PC width
//   NOP_INST      addi x0,x0,0; what decode sees when there is no real instruction
//   fetch_state_e fetch buffer mode: RUN accepts responses, DRAIN discards them
//   fetch_entry_t one queued inst_mem response {pc, inst}
package chronos_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifid_fetch_buffer_fifo.sv
// fetch_fifo: small synchronous FIFO holding queued inst_mem responses.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   clear           synchronous flush of all entries (wins over push/pop)
//   push, wdata     enqueue at tail; ignored when full
//   pop, rdata      dequeue head; rdata always shows the current head
//   count           occupancy 0..DEPTH
//   full, empty     occupancy flags
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifid_fetch_buffer.sv
// ifid_fetch_buffer: decoupling queue plus IF/ID register between inst_mem and decode.
// Ports:
//   clk, rst                              clock, asynchronous active-low reset
//   fetch_data_valid, fetch_data, fetch_pc inst_mem response
//   fetch_ready                           fetch may issue a request (state/count only)
//   ifid_write                            hazard-unit advance enable (0 = hold ID)
//   kill                                  redirect flush
//   id_inst, id_pc, id_valid              registered decode-stage outputs
//   overflow                              sticky: response arrived with the queue full
module ifid_fetch_buffer
  import chronos_pkg::*;
#(
  parameter int              DEPTH        = 4,
  parameter int              XLEN         = chronos_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INST     = chronos_pkg::NOP_INST,
  parameter int              DRAIN_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_data_valid,
  input  logic [XLEN-1:0] fetch_data,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_ready,
  input  logic            ifid_write,
  input  logic            kill,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid,
  output logic            overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  fetch_state_e      state;
  logic [DW-1:0]     drain_cnt;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic [2*XLEN-1:0] head;
  logic              run;
  logic              bypass;
  logic              do_pop;
  logic              do_push;
  logic              ovf_set;

  assign run = (state == RUN);

  // An empty queue lets a fresh response go straight to ID without a queue cycle.
  assign bypass  = run && !kill && ifid_write && empty && fetch_data_valid;
  assign do_pop  = !kill && ifid_write && !empty;
  assign do_push = run && !kill && fetch_data_valid && !bypass && !full;
  assign ovf_set = run && !kill && fetch_data_valid && !bypass && full;

  // One slot stays free for the response to a request issued this cycle.
  assign fetch_ready = run && (count <= CW'(DEPTH - 2));

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (kill),
    .push  (do_push),
    .wdata ({fetch_pc, fetch_data}),
    .pop   (do_pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // DRAIN lasts DRAIN_CYCLES cycles: the last decrement already returns to RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else if (kill) begin
      state     <= DRAIN;
      drain_cnt <= DW'(DRAIN_CYCLES);
    end else if (state == DRAIN) begin
      if (drain_cnt <= DW'(1)) begin
        state     <= RUN;
        drain_cnt <= '0;
      end else begin
        drain_cnt <= drain_cnt - DW'(1);
      end
    end
  end

  // id_pc is left alone on bubbles so it keeps pointing at the last real instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_inst  <= NOP_INST;
      id_pc    <= '0;
      id_valid <= 1'b0;
    end else if (kill) begin
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (ifid_write) begin
      if (!empty) begin
        id_pc    <= head[2*XLEN-1:XLEN];
        id_inst  <= head[XLEN-1:0];
        id_valid <= 1'b1;
      end else if (bypass) begin
        id_pc    <= fetch_pc;
        id_inst  <= fetch_data;
        id_valid <= 1'b1;
      end else begin
        id_inst  <= NOP_INST;
        id_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifid_fetch_buffer.sv
module tb_ifid_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam int          DRAIN = 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_data_valid = 1'b0;
  logic [31:0] fetch_data = '0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_ready;
  logic        ifid_write = 1'b0;
  logic        kill = 1'b0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        overflow;

  always #5 clk = ~clk;

  ifid_fetch_buffer #(
    .DEPTH        (DEPTH),
    .XLEN         (32),
    .NOP_INST     (NOP),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_data_valid (fetch_data_valid),
    .fetch_data       (fetch_data),
    .fetch_pc         (fetch_pc),
    .fetch_ready      (fetch_ready),
    .ifid_write       (ifid_write),
    .kill             (kill),
    .id_inst          (id_inst),
    .id_pc            (id_pc),
    .id_valid         (id_valid),
    .overflow         (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of responses plus the ID register contents.
  logic [63:0] m_q[$];
  int          drain_left;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_ovf;
  bit          chk_en = 1'b0;

  function automatic bit m_ready();
    return (drain_left == 0) && (m_q.size() <= DEPTH - 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    drain_left = 0;
    m_inst     = NOP;
    m_pc       = '0;
    m_valid    = 1'b0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_step();
    int sz      = m_q.size();
    bit running = (drain_left == 0);
    bit byp     = 1'b0;
    if (kill) begin
      m_q.delete();
      m_inst     = NOP;
      m_valid    = 1'b0;
      drain_left = DRAIN;
    end else begin
      if (ifid_write) begin
        if (sz > 0) begin
          {m_pc, m_inst} = m_q.pop_front();
          m_valid = 1'b1;
        end else if (running && fetch_data_valid) begin
          m_inst  = fetch_data;
          m_pc    = fetch_pc;
          m_valid = 1'b1;
          byp     = 1'b1;
        end else begin
          m_inst  = NOP;
          m_valid = 1'b0;
        end
      end
      if (running && fetch_data_valid && !byp) begin
        if (sz < DEPTH) m_q.push_back({fetch_pc, fetch_data});
        else m_ovf = 1'b1;
      end
      if (!running) drain_left--;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("cmp_id_inst", id_inst, m_inst);
      chk("cmp_id_pc", id_pc, m_pc);
      chk("cmp_id_valid", 32'(id_valid), 32'(m_valid));
      chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
      chk("cmp_fetch_ready", 32'(fetch_ready), 32'(m_ready()));
    end
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic [31:0] p,
                     input logic w, input logic k);
    fetch_data_valid = v;
    fetch_data       = d;
    fetch_pc         = p;
    ifid_write       = w;
    kill             = k;
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] seq[$];

  initial begin
    model_reset();
    #12;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_inst", id_inst, 32'h0000_0013);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Streaming through the bypass path
    cyc(1'b1, 32'h0050_0093, 32'h0, 1'b1, 1'b0);
    chk("stream0_inst", id_inst, 32'h0050_0093);
    chk("stream0_valid", 32'(id_valid), 32'd1);
    cyc(1'b1, 32'h00A0_0113, 32'h4, 1'b1, 1'b0);
    chk("stream1_inst", id_inst, 32'h00A0_0113);
    chk("stream1_pc", id_pc, 32'h4);
    chk("stream_ready", 32'(fetch_ready), 32'd1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bubble_inst", id_inst, 32'h0000_0013);
    chk("bubble_pc_held", id_pc, 32'h4);

    // Stall: three responses queue up while ID holds
    cyc(1'b1, 32'h0000_0111, 32'h08, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0222, 32'h0C, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0333, 32'h10, 1'b0, 1'b0);
    chk("stall_pc_frozen", id_pc, 32'h4);
    chk("stall_valid_frozen", 32'(id_valid), 32'd0);
    chk("stall_ready", 32'(fetch_ready), 32'd0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop0", id_inst, 32'h0000_0111);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop1", id_inst, 32'h0000_0222);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pop2", id_inst, 32'h0000_0333);
    chk("pop2_pc", id_pc, 32'h10);

    // Flush with two queued entries and responses around the kill
    cyc(1'b1, 32'h0000_0444, 32'h14, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0555, 32'h18, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_0666, 32'h1C, 1'b1, 1'b1);
    chk("kill_inst", id_inst, 32'h0000_0013);
    chk("kill_valid", 32'(id_valid), 32'd0);
    chk("kill_pc_held", id_pc, 32'h10);
    chk("drain_ready", 32'(fetch_ready), 32'd0);
    cyc(1'b1, 32'h0000_0777, 32'h20, 1'b1, 1'b0);
    chk("drain_drop", id_inst, 32'h0000_0013);
    chk("run_ready", 32'(fetch_ready), 32'd1);
    cyc(1'b1, 32'h0000_0888, 32'h24, 1'b1, 1'b0);
    chk("post_flush_inst", id_inst, 32'h0000_0888);
    chk("post_flush_pc", id_pc, 32'h24);

    // Wrap: ten entries with random stalls, requests only when ready
    begin
      int sent = 0;
      for (int c = 0; c < 200 && seq.size() < 10; c++) begin
        logic w;
        logic v;
        w = ($urandom_range(0, 2) != 0);
        v = (sent < 10) && m_ready() && ($urandom_range(0, 3) != 0);
        cyc(v, 32'h1000 + 32'(sent), 32'h100 + 32'(sent * 4), w, 1'b0);
        if (v) sent++;
        if (w && id_valid) seq.push_back(id_inst);
      end
      chk("wrap_count", 32'(seq.size()), 32'd10);
      for (int i = 0; i < 10 && i < seq.size(); i++)
        chk("wrap_order", seq[i], 32'h1000 + 32'(i));
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Overflow: five responses while stalled, fifth is dropped
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h2000 + 32'(i), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
      if (i == 3) chk("ovf_before", 32'(overflow), 32'd0);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("ovf_pop", id_inst, 32'h2000 + 32'(i));
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("ovf_fifth_dropped", 32'(id_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset mid-stream with three entries queued
    cyc(1'b1, 32'h0000_3000, 32'h300, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_3001, 32'h304, 1'b1, 1'b0);
    cyc(1'b1, 32'h0000_3002, 32'h308, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_3003, 32'h30C, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(id_valid), 32'd1);
    chk("pre_rst_ready", 32'(fetch_ready), 32'd0);
    fetch_data_valid = 1'b0;
    ifid_write       = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_inst", id_inst, 32'h0000_0013);
    chk("arst_valid", 32'(id_valid), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_pc", id_pc, 32'h0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(fetch_ready), 32'd1);
    cyc(1'b1, 32'h0000_4000, 32'h400, 1'b1, 1'b0);
    chk("post_rst_bypass", id_inst, 32'h0000_4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
